// File: rtl/reg_dump_defs_pkg.sv
// Shared definitions for the register-dump sequencer: FSM encoding and the
// register-file geometry defaults also used by the processor top.
package reg_dump_defs;

    localparam int REG_ADDR_BITS = 3;
    localparam int DATA_WIDTH    = 16;
    localparam int TOTAL_REG     = 8;
    localparam int READ_LATENCY  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } dump_state_t;

    // Width of the settle down-counter; one spare bit keeps latency 0 legal.
    function automatic int settle_cnt_width(input int latency);
        return $clog2(latency + 1) + 1;
    endfunction

endpackage

// File: rtl/dump_settle_timer.sv
// Loadable down-counter that measures how long a new register select has
// been presented to the readback port; expire marks the last settle cycle.
module dump_settle_timer
    import reg_dump_defs::*;
#(
    parameter int ReadLatency = READ_LATENCY
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int              CW       = settle_cnt_width(ReadLatency);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(ReadLatency);
    localparam logic [CW-1:0]   ONE      = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    // Loaded with ReadLatency, so zero is reached after ReadLatency+1 cycles.
    assign expire = (r_count == '0);

endmodule

// File: rtl/reg_dump_sequencer.sv
// Steps the processor readback select through every register, waits for the
// data to settle, and streams {index, value} beats while summing the values.
module reg_dump_sequencer
    import reg_dump_defs::*;
#(
    parameter int RegAddrBits = REG_ADDR_BITS,
    parameter int DataWidth   = DATA_WIDTH,
    parameter int TotalReg    = TOTAL_REG,
    parameter int ReadLatency = READ_LATENCY
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    output logic [RegAddrBits-1:0] inr,
    input  logic [DataWidth-1:0]   out_value,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [RegAddrBits-1:0] dump_index,
    output logic [DataWidth-1:0]   dump_data,
    output logic                   busy,
    output logic                   done,
    output logic [DataWidth-1:0]   checksum
);

    localparam logic [RegAddrBits-1:0] LAST_IDX = RegAddrBits'(TotalReg - 1);
    localparam logic [RegAddrBits-1:0] IDX_ONE  = RegAddrBits'(1);

    dump_state_t            r_state;
    logic [RegAddrBits-1:0] r_inr;
    logic                   r_valid;
    logic [RegAddrBits-1:0] r_index;
    logic [DataWidth-1:0]   r_data;
    logic                   r_busy;
    logic                   r_done;
    logic [DataWidth-1:0]   r_checksum;

    logic w_handshake;
    logic w_last;
    logic w_load;
    logic w_en;
    logic w_expire;

    assign w_handshake = (r_state == OUTPUT) && r_valid && dump_ready;
    assign w_last      = (r_index == LAST_IDX);

    // Restart the settle window on every edge that enters SETTLE.
    assign w_load = ((r_state == IDLE) && start) || (w_handshake && !w_last);
    assign w_en   = (r_state == SETTLE);

    dump_settle_timer #(
        .ReadLatency (ReadLatency)
    ) u_settle_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (w_load),
        .en     (w_en),
        .expire (w_expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_inr      <= '0;
            r_valid    <= 1'b0;
            r_index    <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= SETTLE;
                        r_checksum <= '0;
                        r_inr      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        r_data  <= out_value;
                        r_index <= r_inr;
                        r_valid <= 1'b1;
                        r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    // inr is untouched while stalled so the readback stays put.
                    if (w_handshake) begin
                        r_checksum <= r_checksum + r_data;
                        r_valid    <= 1'b0;
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_inr   <= r_inr + IDX_ONE;
                            r_state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_inr   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign inr        = r_inr;
    assign dump_valid = r_valid;
    assign dump_index = r_index;
    assign dump_data  = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign checksum   = r_checksum;

endmodule
